// File: rtl/dma_pkg.sv
// Shared types and default sizes for the DMA copy engine.
// ABORT exists only when DMA_TIMEOUT_EN is defined.
package dma_pkg;

  localparam int unsigned ADDR_W_DEF  = 48;
  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned LEN_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
`ifdef DMA_TIMEOUT_EN
    FINISH,
    ABORT
`else
    FINISH
`endif
  } state_e;

endpackage

// File: rtl/dma_watchdog.sv
// Read-data watchdog: counts cycles spent in RD_WAIT and flags expiry.
// Compiled only when DMA_TIMEOUT_EN is defined.
`ifdef DMA_TIMEOUT_EN
module dma_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic active,
  input  logic mem_valid,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) cnt_d = '0;
    else if (active) cnt_d = mem_valid ? '0 : cnt_q + CW'(1);
  end

  // Fires on the last waiting cycle so the abort lands TIMEOUT cycles after entry.
  assign expired = active && !mem_valid && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/dma_copy_engine.sv
// Word-by-word memory-to-memory copy initiator: read, wait for data, write.
// Define DMA_TIMEOUT_EN to add the read-data watchdog and the err/ABORT path.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wd_expired;

  logic              cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic              done_q, done_d, err_q, err_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

`ifdef DMA_TIMEOUT_EN
  dma_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .load      (state_d == RD_WAIT && state_q != RD_WAIT),
    .active    (state_q == RD_WAIT),
    .mem_valid (mem_valid),
    .expired   (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        src_d   = cmd_src;
        dst_d   = cmd_dst;
        rem_d   = cmd_len;
        state_d = (cmd_len == '0) ? FINISH : RD_REQ;
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_valid) begin
          data_d  = mem_rdata;
          state_d = WR_REQ;
        end
`ifdef DMA_TIMEOUT_EN
        else if (wd_expired) state_d = ABORT;
`endif
      end
      WR_REQ: begin
        src_d   = src_q + ADDR_W'(1);
        dst_d   = dst_q + ADDR_W'(1);
        rem_d   = rem_q - LEN_W'(1);
        state_d = (rem_q == LEN_W'(1)) ? FINISH : RD_REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
`ifdef DMA_TIMEOUT_EN
    err_d       = (state_d == ABORT);
`else
    err_d       = 1'b0;
`endif
    mem_req_d   = (state_d == RD_REQ) || (state_d == WR_REQ);
    mem_we_d    = (state_d == WR_REQ);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == RD_REQ) mem_addr_d = src_d;
    if (state_d == WR_REQ) begin
      mem_addr_d  = dst_d;
      mem_wdata_d = data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      data_q      <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: memory responder, access log and
// a per-command reference of addresses, data and cycle timing.
module tb_dma_copy_engine;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [47:0] cmd_src, cmd_dst;
  logic [15:0] cmd_len;
  logic        mem_req, mem_we, mem_valid;
  logic [47:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        busy, done, err;

  dma_copy_engine #(.ADDR_W(48), .DATA_W(64), .LEN_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit spur = 0;
  bit mute = 0;

  logic [47:0] rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [47:0] wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_q[$];
  int          err_q[$];
  logic [63:0] wmem[logic [47:0]];
  logic [63:0] imem[logic [47:0]];
  int          rd_req_cyc = -10;
  logic [47:0] rd_req_addr = '0;

  function automatic logic [63:0] rd_mem(input logic [47:0] a);
    if (wmem.exists(a)) return wmem[a];
    if (imem.exists(a)) return imem[a];
    return {a[31:0] ^ 32'h5A5A_C3C3, a[47:16]};
  endfunction

  // Responder: read data one cycle after the request; optional spurious valids.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rd_req_cyc == cyc - 1 && !mute) begin
      mem_valid = 1'b1; mem_rdata = rd_mem(rd_req_addr);
    end else if (spur) begin
      mem_valid = 1'b1; mem_rdata = 64'hDEAD;
    end else begin
      mem_valid = 1'b0; mem_rdata = 64'h0;
    end
  end

  // Monitor samples mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && !mem_we) begin
        rd_addr_q.push_back(mem_addr); rd_cyc_q.push_back(cyc);
        rd_req_cyc = cyc; rd_req_addr = mem_addr;
      end
      if (mem_req && mem_we) begin
        wr_addr_q.push_back(mem_addr); wr_data_q.push_back(mem_wdata);
        wr_cyc_q.push_back(cyc); wmem[mem_addr] = mem_wdata;
      end
      if (done) done_q.push_back(cyc);
      if (err)  err_q.push_back(cyc);
    end
  end

  task automatic issue(input logic [47:0] s, input logic [47:0] d, input logic [15:0] l,
                       input bit hold, output int t);
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    nchk++;
    if (!ok) begin nerr++; $display("FAIL cmd_accept: cmd_ready=%0b, required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_len = l;
    t = cyc;
    @(posedge clk); #1;
    if (hold) begin cmd_src = ~s; cmd_dst = ~d; cmd_len = 16'd3; end
    else cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, output bit got);
    got = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (done_q.size() > d0 || err_q.size() > e0) begin got = 1; break; end
    end
  endtask

  task automatic test_copy(input string nm, input logic [47:0] s, input logic [47:0] d,
                           input int len, input bit hold);
    int t;
    bit got;
    int r0 = rd_addr_q.size();
    int w0 = wr_addr_q.size();
    int d0 = done_q.size();
    int e0 = err_q.size();
    int act;
    logic [63:0] exp_d[$];
    for (int i = 0; i < len; i++) exp_d.push_back(rd_mem(s + 48'(i)));
    issue(s, d, 16'(len), hold, t);
    wait_end(d0, e0, got);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    act = (done_q.size() > d0) ? done_q[d0] : -1;
    nchk++;
    if (!got || done_q.size() != d0 + 1 || act != t + 1 + 3 * len) begin
      nerr++; $display("FAIL %s done_cycle: got %0d (count %0d), required %0d", nm, act - t,
                       done_q.size() - d0, 1 + 3 * len);
    end
    nchk++;
    if (err_q.size() != e0) begin nerr++; $display("FAIL %s err_pulse: got %0d, required 0", nm, err_q.size() - e0); end
    nchk++;
    if (rd_addr_q.size() - r0 != len || wr_addr_q.size() - w0 != len) begin
      nerr++; $display("FAIL %s access_count: reads %0d writes %0d, required %0d", nm,
                       rd_addr_q.size() - r0, wr_addr_q.size() - w0, len);
    end
    for (int i = 0; i < len; i++) begin
      if (r0 + i < rd_addr_q.size()) begin
        nchk++;
        if (rd_addr_q[r0+i] !== s + 48'(i) || rd_cyc_q[r0+i] != t + 1 + 3 * i) begin
          nerr++; $display("FAIL %s read[%0d]: addr %h @%0d, required %h @%0d", nm, i,
                           rd_addr_q[r0+i], rd_cyc_q[r0+i] - t, s + 48'(i), 1 + 3 * i);
        end
      end
      if (w0 + i < wr_addr_q.size()) begin
        nchk++;
        if (wr_addr_q[w0+i] !== d + 48'(i) || wr_data_q[w0+i] !== exp_d[i] ||
            wr_cyc_q[w0+i] != t + 3 + 3 * i) begin
          nerr++; $display("FAIL %s write[%0d]: addr %h data %h @%0d, required %h %h @%0d", nm, i,
                           wr_addr_q[w0+i], wr_data_q[w0+i], wr_cyc_q[w0+i] - t,
                           d + 48'(i), exp_d[i], 3 + 3 * i);
        end
      end
    end
    nchk++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      nerr++; $display("FAIL %s idle_after: busy %b cmd_ready %b, required 0 1", nm, busy, cmd_ready);
    end
  endtask

  task automatic test_reset;
    logic [8:0] got;
    repeat (2) @(negedge clk);
    got = {cmd_ready, mem_req, mem_we, busy, done, err, |mem_addr, |mem_wdata, 1'b0};
    nchk++;
    if (got !== 9'b1_0000_0000) begin
      nerr++; $display("FAIL reset_values: {rdy,req,we,busy,done,err,addr,wdata}=%b, required 10000000", got[8:1]);
    end
  endtask

  task automatic test_basic;
    logic [63:0] v[4] = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
                          64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
    for (int i = 0; i < 4; i++) imem[48'h100 + 48'(i)] = v[i];
    test_copy("basic", 48'h100, 48'h200, 4, 0);
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (rd_mem(48'h200 + 48'(i)) !== v[i]) begin
        nerr++; $display("FAIL basic_mem[%0d]: got %h, required %h", i, rd_mem(48'h200 + 48'(i)), v[i]);
      end
    end
  endtask

  // Zero-length command followed immediately by another one.
  task automatic test_back_to_back;
    int t1, t2, d0, w0;
    bit got;
    d0 = done_q.size(); w0 = wr_addr_q.size();
    issue(48'h500, 48'h600, 16'd0, 0, t1);
    wait_end(d0, err_q.size(), got);
    nchk++;
    if (!got || done_q[d0] != t1 + 1) begin
      nerr++; $display("FAIL zero_len_done: got %0d, required 1", got ? done_q[d0] - t1 : -1);
    end
    issue(48'h700, 48'h800, 16'd2, 0, t2);
    nchk++;
    if (t2 != t1 + 2) begin nerr++; $display("FAIL zero_len_next_accept: got T+%0d, required T+2", t2 - t1); end
    nchk++;
    if (wr_addr_q.size() != w0) begin nerr++; $display("FAIL zero_len_no_req: got %0d writes, required 0", wr_addr_q.size() - w0); end
    wait_end(d0 + 1, err_q.size(), got);
    nchk++;
    if (!got || done_q[d0+1] != t2 + 7 || wr_addr_q.size() != w0 + 2 || wr_addr_q[w0+1] !== 48'h801) begin
      nerr++; $display("FAIL b2b_second: done @%0d writes %0d, required @7 and 2", done_q[d0+1] - t2, wr_addr_q.size() - w0);
    end
  endtask

  task automatic test_busy_spurious;
    spur = 1;
    test_copy("spurious_hold", 48'h900, 48'hA00, 5, 1);
    spur = 0;
  endtask

  task automatic test_reset_mid;
    int t;
    bit seen = 0;
    int r0 = rd_addr_q.size();
    int d0, e0;
    issue(48'h3000, 48'h4000, 16'd4, 0, t);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (rd_addr_q.size() >= r0 + 2) begin seen = 1; break; end
    end
    @(posedge clk); #2;
    nchk++;
    if (!seen || busy !== 1'b1) begin nerr++; $display("FAIL rst_mid_precond: busy %b seen %0b, required 1 1", busy, seen); end
    rst = 1'b1; #1;
    nchk++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      nerr++; $display("FAIL rst_mid_async: req %b busy %b rdy %b, required 0 0 1", mem_req, busy, cmd_ready);
    end
    d0 = done_q.size(); e0 = err_q.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    nchk++;
    if (done_q.size() != d0 || err_q.size() != e0) begin
      nerr++; $display("FAIL rst_mid_no_pulse: done %0d err %0d, required 0 0", done_q.size() - d0, err_q.size() - e0);
    end
    test_copy("after_reset", 48'h3100, 48'h4100, 3, 0);
  endtask

`ifdef DMA_TIMEOUT_EN
  task automatic test_timeout;
    int t;
    bit got;
    int r0 = rd_addr_q.size(), w0 = wr_addr_q.size();
    int d0 = done_q.size(), e0 = err_q.size();
    mute = 1;
    issue(48'h5000, 48'h6000, 16'd2, 0, t);
    wait_end(d0, e0, got);
    repeat (3) @(negedge clk);
    #1;
    nchk++;
    if (!got || err_q.size() != e0 + 1 || err_q[e0] != t + 2 + TO) begin
      nerr++; $display("FAIL timeout_err: got @%0d, required @%0d", got ? err_q[e0] - t : -1, 2 + TO);
    end
    nchk++;
    if (wr_addr_q.size() != w0 || done_q.size() != d0 || rd_addr_q.size() != r0 + 1) begin
      nerr++; $display("FAIL timeout_accesses: writes %0d done %0d reads %0d, required 0 0 1",
                       wr_addr_q.size() - w0, done_q.size() - d0, rd_addr_q.size() - r0);
    end
    nchk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL timeout_idle: rdy %b busy %b, required 1 0", cmd_ready, busy);
    end
    mute = 0;
  endtask
`endif

  initial begin
    logic [47:0] s, d;
    rst = 1'b1; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    mem_valid = 1'b0; mem_rdata = '0;
    test_reset();
    @(negedge clk); rst = 1'b0;
    test_basic();
    test_back_to_back();
    test_copy("addr_wrap", 48'hFFFF_FFFF_FFFF, 48'h10, 2, 0);
    for (int n = 0; n < 5; n++) begin
      s = {16'($urandom), 32'($urandom)};
      d = s + 48'h1000 + 48'($urandom_range(0, 100));
      test_copy("random", s, d, $urandom_range(1, 6), 0);
    end
    test_busy_spurious();
    test_reset_mid();
`ifdef DMA_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
